// File: rtl/seq_arith_if.sv
// Issue/result bundle for seq_arith_unit: start/operands in, busy/done/result/flags out.
interface seq_arith_if #(
    parameter int WIDTH = 4
);
    logic               i_start;
    logic [WIDTH-1:0]   i_x;
    logic [WIDTH-1:0]   i_y;
    logic [1:0]         i_mode;
    logic               o_busy;
    logic               o_done;
    logic [2*WIDTH-1:0] o_result;
    logic               o_overflow;
    logic               o_divByZero;

    modport master (
        output i_start, i_x, i_y, i_mode,
        input  o_busy, o_done, o_result, o_overflow, o_divByZero
    );

    modport slave (
        input  i_start, i_x, i_y, i_mode,
        output o_busy, o_done, o_result, o_overflow, o_divByZero
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/mul/div unit: single-cycle signed add/sub, iterative shift-add
// multiply and restoring divide, with results held in registers between operations.
module seq_arith_unit #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    seq_arith_if.slave bus
);
    localparam int         CW       = $clog2(WIDTH + 1);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_MUL = 2'b10;
    localparam logic [1:0] MODE_DIV = 2'b11;

    typedef enum logic {IDLE, CALC} stateT;

    stateT              r_state;
    stateT              w_stateNext;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [2*WIDTH-1:0] r_result;
    logic               r_overflow;
    logic               r_divByZero;
    logic               r_done;

    logic               w_accept;
    logic               w_complete;
    logic [WIDTH-1:0]   w_addB;
    logic [WIDTH:0]     w_sum;
    logic               w_carryIntoMsb;
    logic               w_addOvf;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH:0]     w_shifted;
    logic               w_fits;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;
    logic               w_divZero;
    logic               w_longOp;
    logic [2*WIDTH-1:0] w_resultNext;
    logic               w_ovfNext;
    logic               w_dbzNext;

    // Subtraction reuses the adder as x + ~y + 1; overflow is carry-in vs carry-out of the MSB.
    assign w_addB         = (r_mode == MODE_SUB) ? ~r_opB : r_opB;
    assign w_sum          = {1'b0, r_opA} + {1'b0, w_addB} + {{WIDTH{1'b0}}, (r_mode == MODE_SUB)};
    assign w_carryIntoMsb = r_opA[WIDTH-1] ^ w_addB[WIDTH-1] ^ w_sum[WIDTH-1];
    assign w_addOvf       = w_carryIntoMsb ^ w_sum[WIDTH];

    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Restoring step: the remainder is always below y, so the low WIDTH bits of the difference suffice.
    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_opB});
    assign w_diff    = w_shifted[WIDTH-1:0] - r_opB;
    assign w_remNext = w_fits ? w_diff : w_shifted[WIDTH-1:0];
    assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};
    assign w_divZero = (r_opB == '0);

    assign w_longOp = (bus.i_mode == MODE_MUL) || ((bus.i_mode == MODE_DIV) && (bus.i_y != '0));

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_accept    = 1'b1;
                    w_stateNext = CALC;
                end
            end
            CALC: begin
                if (r_count == CW'(1)) begin
                    w_complete  = 1'b1;
                    w_stateNext = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_resultNext = '0;
        w_ovfNext    = 1'b0;
        w_dbzNext    = 1'b0;
        case (r_mode)
            MODE_ADD, MODE_SUB: begin
                w_resultNext = {{WIDTH{w_sum[WIDTH-1]}}, w_sum[WIDTH-1:0]};
                w_ovfNext    = w_addOvf;
            end
            MODE_MUL: begin
                w_resultNext = w_accNext;
                w_ovfNext    = |w_accNext[2*WIDTH-1:WIDTH];
            end
            MODE_DIV: begin
                if (w_divZero) begin
                    w_resultNext = {r_opA, {WIDTH{1'b1}}};
                    w_dbzNext    = 1'b1;
                end else begin
                    w_resultNext = {w_remNext, w_quoNext};
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // The final iteration's value goes straight into the result register, so partial values never show.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_mode      <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_divByZero <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (w_accept) begin
                r_mode   <= bus.i_mode;
                r_opA    <= bus.i_x;
                r_opB    <= bus.i_y;
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, bus.i_x};
                r_mplier <= bus.i_y;
                r_rem    <= '0;
                r_quo    <= bus.i_x;
                r_count  <= w_longOp ? CW'(WIDTH) : CW'(1);
            end else if (r_state == CALC) begin
                r_count  <= r_count - CW'(1);
                r_acc    <= w_accNext;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_rem    <= w_remNext;
                r_quo    <= w_quoNext;
                if (w_complete) begin
                    r_result    <= w_resultNext;
                    r_overflow  <= w_ovfNext;
                    r_divByZero <= w_dbzNext;
                end
            end
        end
    end

    assign bus.o_busy      = (r_state == CALC);
    assign bus.o_done      = r_done;
    assign bus.o_result    = r_result;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_divByZero = r_divByZero;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit at WIDTH=4 and WIDTH=8 with a per-DUT scoreboard.
module tb_seq_arith_unit;
    typedef struct {
        int          sel;
        logic [1:0]  mode;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vecT;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic        ovf;
        logic        dbz;
        int          lat;
    } expT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        startS [2];
    logic [7:0]  xS     [2];
    logic [7:0]  yS     [2];
    logic [1:0]  modeS  [2];
    logic        busyS  [2];
    logic        doneS  [2];
    logic [15:0] resS   [2];
    logic        ovfS   [2];
    logic        dbzS   [2];

    seq_arith_if #(.WIDTH(4)) bus4 ();
    seq_arith_if #(.WIDTH(8)) bus8 ();

    assign bus4.i_start = startS[0];
    assign bus4.i_x     = xS[0][3:0];
    assign bus4.i_y     = yS[0][3:0];
    assign bus4.i_mode  = modeS[0];
    assign busyS[0]     = bus4.o_busy;
    assign doneS[0]     = bus4.o_done;
    assign resS[0]      = {8'h00, bus4.o_result};
    assign ovfS[0]      = bus4.o_overflow;
    assign dbzS[0]      = bus4.o_divByZero;

    assign bus8.i_start = startS[1];
    assign bus8.i_x     = xS[1];
    assign bus8.i_y     = yS[1];
    assign bus8.i_mode  = modeS[1];
    assign busyS[1]     = bus8.o_busy;
    assign doneS[1]     = bus8.o_done;
    assign resS[1]      = bus8.o_result;
    assign ovfS[1]      = bus8.o_overflow;
    assign dbzS[1]      = bus8.o_divByZero;

    seq_arith_unit #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    seq_arith_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    int  compared   = 0;
    int  mismatched = 0;
    vecT vecs[$];
    expT sb0[$];
    expT sb1[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic expT model(input int w, input logic [1:0] m, input int a, input int b,
                                  input string name);
        expT e;
        int  mask;
        int  sa;
        int  sb;
        int  s;
        int  t;
        int  p;
        mask   = (1 << w) - 1;
        e.name = name;
        e.ovf  = 1'b0;
        e.dbz  = 1'b0;
        e.res  = 16'h0000;
        e.lat  = w;
        case (m)
            2'b00, 2'b01: begin
                sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
                sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
                s  = (m == 2'b00) ? sa + sb : sa - sb;
                e.ovf = (s > (mask >> 1)) || (s < -(1 << (w - 1)));
                t = s & mask;
                if (t >= (1 << (w - 1))) t = t | (mask << w);
                e.res = 16'(t);
                e.lat = 1;
            end
            2'b10: begin
                p     = a * b;
                e.res = 16'(p);
                e.ovf = (p > mask);
            end
            default: begin
                if (b == 0) begin
                    e.res = 16'((a << w) | mask);
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else begin
                    e.res = 16'(((a % b) << w) | (a / b));
                end
            end
        endcase
        return e;
    endfunction

    task automatic addVec(input int s, input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] r, input logic o, input logic d, input int l);
        vecT v;
        v.sel = s; v.mode = m; v.x = a; v.y = b; v.res = r; v.ovf = o; v.dbz = d; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic pushExp(input int sel, input expT e);
        if (sel == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endtask

    // Drives one issue cycle and ends on the negedge just after the accepting edge.
    task automatic applyStimulus(input int sel, input logic [1:0] m, input logic [7:0] a,
                                 input logic [7:0] b, input expT e);
        @(negedge clk);
        startS[sel] = 1'b1;
        modeS[sel]  = m;
        xS[sel]     = a;
        yS[sel]     = b;
        pushExp(sel, e);
        @(negedge clk);
        startS[sel] = 1'b0;
        modeS[sel]  = 2'($urandom_range(0, 3));
        xS[sel]     = 8'($urandom);
        yS[sel]     = 8'($urandom);
        checkVal($sformatf("%s busy after issue", e.name), {15'd0, busyS[sel]}, 16'd1);
    endtask

    task automatic checkOutput(input int sel, input int cyc);
        expT e;
        if ((sel == 0 && sb0.size() == 0) || (sel == 1 && sb1.size() == 0)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL dut%0d unexpected done: got done=1, required no pending op", sel);
            return;
        end
        if (sel == 0) e = sb0.pop_front();
        else          e = sb1.pop_front();
        checkVal($sformatf("%s result", e.name), resS[sel], e.res);
        checkVal($sformatf("%s overflow", e.name), {15'd0, ovfS[sel]}, {15'd0, e.ovf});
        checkVal($sformatf("%s div_by_zero", e.name), {15'd0, dbzS[sel]}, {15'd0, e.dbz});
        checkVal($sformatf("%s latency", e.name), 16'(cyc), 16'(e.lat));
        checkVal($sformatf("%s busy at done", e.name), {15'd0, busyS[sel]}, 16'd0);
    endtask

    task automatic waitDone(input int sel, input int startCyc);
        int cyc;
        bit seen;
        cyc  = startCyc;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (doneS[sel]) seen = 1'b1;
        end
        if (seen) begin
            checkOutput(sel, cyc);
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL dut%0d timeout: no done after %0d cycles, required done", sel, cyc);
            if (sel == 0 && sb0.size() > 0) void'(sb0.pop_front());
            if (sel == 1 && sb1.size() > 0) void'(sb1.pop_front());
        end
    endtask

    task automatic runOp(input int sel, input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input expT e);
        applyStimulus(sel, m, a, b, e);
        waitDone(sel, 0);
        @(negedge clk);
        checkVal($sformatf("%s done pulse width", e.name), {15'd0, doneS[sel]}, 16'd0);
        checkVal($sformatf("%s result hold", e.name), resS[sel], e.res);
    endtask

    initial begin
        expT        e;
        logic [1:0] hm [6];
        logic [7:0] hx [6];
        logic [7:0] hy [6];
        int         dones;

        for (int i = 0; i < 2; i++) begin
            startS[i] = 1'b0; xS[i] = 8'h00; yS[i] = 8'h00; modeS[i] = 2'b00;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkVal($sformatf("dut%0d reset result", i), resS[i], 16'h0000);
            checkVal($sformatf("dut%0d reset busy", i), {15'd0, busyS[i]}, 16'd0);
            checkVal($sformatf("dut%0d reset done", i), {15'd0, doneS[i]}, 16'd0);
            checkVal($sformatf("dut%0d reset flags", i), {14'd0, ovfS[i], dbzS[i]}, 16'd0);
        end

        addVec(0, 2'b00, 8'd7,   8'd1,   16'h00F8, 1'b1, 1'b0, 1);
        addVec(0, 2'b01, 8'd3,   8'd5,   16'h00FE, 1'b0, 1'b0, 1);
        addVec(0, 2'b01, 8'd8,   8'd1,   16'h0007, 1'b1, 1'b0, 1);
        addVec(0, 2'b00, 8'd8,   8'd8,   16'h0000, 1'b1, 1'b0, 1);
        addVec(0, 2'b10, 8'd15,  8'd15,  16'h00E1, 1'b1, 1'b0, 4);
        addVec(0, 2'b10, 8'd3,   8'd5,   16'h000F, 1'b0, 1'b0, 4);
        addVec(0, 2'b11, 8'd13,  8'd4,   16'h0013, 1'b0, 1'b0, 4);
        addVec(0, 2'b11, 8'd9,   8'd0,   16'h009F, 1'b0, 1'b1, 1);
        addVec(0, 2'b11, 8'd9,   8'd2,   16'h0014, 1'b0, 1'b0, 4);
        addVec(1, 2'b10, 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b0, 8);
        addVec(1, 2'b10, 8'd16,  8'd15,  16'h00F0, 1'b0, 1'b0, 8);
        addVec(1, 2'b00, 8'd127, 8'd1,   16'hFF80, 1'b1, 1'b0, 1);
        addVec(1, 2'b01, 8'd128, 8'd1,   16'h007F, 1'b1, 1'b0, 1);
        addVec(1, 2'b11, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 8);
        addVec(1, 2'b11, 8'd5,   8'd0,   16'h05FF, 1'b0, 1'b1, 1);
        addVec(1, 2'b01, 8'd3,   8'd5,   16'hFFFE, 1'b0, 1'b0, 1);

        foreach (vecs[i]) begin
            e.name = $sformatf("vec%0d", i);
            e.res  = vecs[i].res;
            e.ovf  = vecs[i].ovf;
            e.dbz  = vecs[i].dbz;
            e.lat  = vecs[i].lat;
            runOp(vecs[i].sel, vecs[i].mode, vecs[i].x, vecs[i].y, e);
        end

        for (int i = 0; i < 12; i++) begin
            int         s;
            int         w;
            logic [1:0] m;
            logic [7:0] a;
            logic [7:0] b;
            s = i % 2;
            w = (s == 0) ? 4 : 8;
            m = 2'($urandom_range(0, 3));
            a = 8'($urandom_range(0, (1 << w) - 1));
            b = 8'($urandom_range(0, (1 << w) - 1));
            runOp(s, m, a, b, model(w, m, int'(a), int'(b), $sformatf("rand%0d", i)));
        end

        // A second start while busy must be ignored and must not disturb the captured operands.
        e = model(4, 2'b10, 15, 15, "busy start");
        applyStimulus(0, 2'b10, 8'd15, 8'd15, e);
        @(negedge clk);
        startS[0] = 1'b1; modeS[0] = 2'b00; xS[0] = 8'd3; yS[0] = 8'd5;
        @(negedge clk);
        startS[0] = 1'b0;
        waitDone(0, 2);
        @(negedge clk);
        checkVal("busy start no second done", {15'd0, doneS[0]}, 16'd0);

        runOp(0, 2'b11, 8'd9, 8'd0, model(4, 2'b11, 9, 0, "pre-abort div0"));

        // Reset lands on E2 of a multiply: outputs clear and the aborted op never signals done.
        @(negedge clk);
        startS[0] = 1'b1; modeS[0] = 2'b10; xS[0] = 8'd15; yS[0] = 8'd15;
        @(negedge clk);
        startS[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("abort result", resS[0], 16'h0000);
        checkVal("abort busy", {15'd0, busyS[0]}, 16'd0);
        checkVal("abort done", {15'd0, doneS[0]}, 16'd0);
        checkVal("abort flags", {14'd0, ovfS[0], dbzS[0]}, 16'd0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (doneS[0]) dones++;
        end
        checkVal("abort no done", 16'(dones), 16'd0);
        runOp(0, 2'b00, 8'd7, 8'd1, model(4, 2'b00, 7, 1, "post-abort add"));

        // Start held high across alternating modes: each op is taken in the previous op's done cycle.
        hm[0] = 2'b00; hx[0] = 8'd7;  hy[0] = 8'd1;
        hm[1] = 2'b10; hx[1] = 8'd3;  hy[1] = 8'd5;
        hm[2] = 2'b01; hx[2] = 8'd3;  hy[2] = 8'd5;
        hm[3] = 2'b11; hx[3] = 8'd13; hy[3] = 8'd4;
        hm[4] = 2'b11; hx[4] = 8'd9;  hy[4] = 8'd0;
        hm[5] = 2'b10; hx[5] = 8'd15; hy[5] = 8'd15;
        @(negedge clk);
        startS[0] = 1'b1; modeS[0] = hm[0]; xS[0] = hx[0]; yS[0] = hy[0];
        pushExp(0, model(4, hm[0], int'(hx[0]), int'(hy[0]), "hold0"));
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            waitDone(0, 0);
            if (k < 5) begin
                modeS[0] = hm[k+1]; xS[0] = hx[k+1]; yS[0] = hy[k+1];
                pushExp(0, model(4, hm[k+1], int'(hx[k+1]), int'(hy[k+1]), $sformatf("hold%0d", k + 1)));
            end else begin
                startS[0] = 1'b0;
            end
            @(negedge clk);
        end
        checkVal("hold idle at end", {15'd0, busyS[0]}, 16'd0);
        checkVal("hold scoreboard drained", 16'(sb0.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
